// File: rtl/timer_disp_pkg.sv
// Shared constants for the kitchen-timer 7-segment display: glyphs and digit slot indices.
package timer_disp_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  // Anything that is not a decimal digit renders as a dash.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    if (d > 4'd9) return SEG_DASH;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/seg7_time_display_if.sv
// Bundle between the timer core (master) and the display driver (slave).
interface seg7_time_display_if;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic       blank;
  logic       blink_en;
  logic       colon_on;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       range_err;

  modport master (
    output min_in, sec_in, blank, blink_en, colon_on,
    input  seg, dp, an, range_err
  );

  modport slave (
    input  min_in, sec_in, blank, blink_en, colon_on,
    output seg, dp, an, range_err
  );
endinterface

// File: rtl/bin2bcd_6.sv
// Combinational 0..59 binary to two-digit BCD split; flags values above 59.
module bin2bcd_6 (
  input  logic [5:0] bin,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       oor
);

  // Compare chain for the tens digit, remainder for the ones digit.
  always_comb begin
    oor = (bin > 6'd59);
    if (bin >= 6'd50)      tens = 3'd5;
    else if (bin >= 6'd40) tens = 3'd4;
    else if (bin >= 6'd30) tens = 3'd3;
    else if (bin >= 6'd20) tens = 3'd2;
    else if (bin >= 6'd10) tens = 3'd1;
    else                   tens = 3'd0;
    ones = 4'(bin - 6'(tens) * 6'd10);
  end

endmodule

// File: rtl/seg7_time_display.sv
// Four-digit MM.SS multiplexed common-anode display driver with blanking, blink and range flag.
module seg7_time_display
  import timer_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seg7_time_display_if.slave bus
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  logic [RW-1:0] refresh_cnt_q;
  logic [1:0]    digit_idx_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [5:0]    snap_min_q, snap_sec_q;
  logic          range_err_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic          tick;
  logic          force_off;
  logic [2:0]    min_tens, sec_tens;
  logic [3:0]    min_ones, sec_ones;
  logic          min_oor, sec_oor;
  logic [6:0]    digit_seg;

  assign tick      = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
  assign force_off = tick | bus.blank | (bus.blink_en & blink_phase_q);

  bin2bcd_6 u_min_bcd (
    .bin  (snap_min_q),
    .tens (min_tens),
    .ones (min_ones),
    .oor  (min_oor)
  );

  bin2bcd_6 u_sec_bcd (
    .bin  (snap_sec_q),
    .tens (sec_tens),
    .ones (sec_ones),
    .oor  (sec_oor)
  );

  // Scan timing: slot counter and digit index advancing once per slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= DIG_SEC_ONES;
    end else if (tick) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= digit_idx_q + 2'd1;
    end else begin
      refresh_cnt_q <= refresh_cnt_q + RW'(1);
    end
  end

  // Capture inputs only at frame wrap so a frame never mixes two time values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_min_q  <= '0;
      snap_sec_q  <= '0;
      range_err_q <= 1'b0;
    end else if (tick && digit_idx_q == DIG_MIN_TENS) begin
      snap_min_q  <= bus.min_in;
      snap_sec_q  <= bus.sec_in;
      range_err_q <= (bus.min_in > 6'd59) || (bus.sec_in > 6'd59);
    end
  end

  // Blink half-period timer; held cleared while disabled so the display lights at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (!bus.blink_en) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BW'(1);
    end
  end

  // Segment pattern for the digit currently selected by the scan.
  always_comb begin
    digit_seg = SEG_OFF;
    unique case (digit_idx_q)
      DIG_MIN_TENS: begin
        if (min_oor)                          digit_seg = SEG_DASH;
        else if (LZ_BLANK && min_tens == '0) digit_seg = SEG_OFF;
        else                                  digit_seg = seg_glyph({1'b0, min_tens});
      end
      DIG_MIN_ONES: digit_seg = min_oor ? SEG_DASH : seg_glyph(min_ones);
      DIG_SEC_TENS: digit_seg = sec_oor ? SEG_DASH : seg_glyph({1'b0, sec_tens});
      DIG_SEC_ONES: digit_seg = sec_oor ? SEG_DASH : seg_glyph(sec_ones);
    endcase
  end

  // Registered pin drivers; the tick slot doubles as an all-off guard against ghosting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= force_off ? 4'b1111 : ~(4'b0001 << digit_idx_q);
      seg_q <= digit_seg;
      dp_q  <= ~(bus.colon_on && digit_idx_q == DIG_MIN_ONES);
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.range_err = range_err_q;

endmodule
